// File: rtl/countdown_timer_7seg_pkg.sv
// Shared types and constants for the two-digit 7-segment countdown timer.
// Segment patterns are active-high: bit[6:0] = g..a, bit7 = DP, bit8 unused.
package timer_pkg;

  localparam int SEG_W  = 9;
  localparam int DP_BIT = 7;

  localparam logic [SEG_W-1:0] SEG_0     = 9'h03F;
  localparam logic [SEG_W-1:0] SEG_1     = 9'h006;
  localparam logic [SEG_W-1:0] SEG_2     = 9'h05B;
  localparam logic [SEG_W-1:0] SEG_3     = 9'h04F;
  localparam logic [SEG_W-1:0] SEG_4     = 9'h066;
  localparam logic [SEG_W-1:0] SEG_5     = 9'h06D;
  localparam logic [SEG_W-1:0] SEG_6     = 9'h07D;
  localparam logic [SEG_W-1:0] SEG_7     = 9'h007;
  localparam logic [SEG_W-1:0] SEG_8     = 9'h07F;
  localparam logic [SEG_W-1:0] SEG_9     = 9'h06F;
  localparam logic [SEG_W-1:0] SEG_BLANK = 9'h000;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    PAUSE = 2'd2,
    DONE  = 2'd3
  } state_e;

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

  function automatic logic [SEG_W-1:0] seg_of(input logic [3:0] d);
    case (d)
      4'd0:    return SEG_0;
      4'd1:    return SEG_1;
      4'd2:    return SEG_2;
      4'd3:    return SEG_3;
      4'd4:    return SEG_4;
      4'd5:    return SEG_5;
      4'd6:    return SEG_6;
      4'd7:    return SEG_7;
      4'd8:    return SEG_8;
      4'd9:    return SEG_9;
      default: return SEG_BLANK;
    endcase
  endfunction

  // Clip to 99 and split into digits with a compare ladder (load path only).
  function automatic bcd_t bin_to_bcd(input logic [6:0] v);
    logic [6:0] c;
    bcd_t       b;
    c      = (v > 7'd99) ? 7'd99 : v;
    b.tens = 4'd0;
    for (int i = 1; i < 10; i++)
      if (c >= 7'(10 * i)) b.tens = 4'(i);
    b.units = 4'(c - 7'(10 * int'(b.tens)));
    return b;
  endfunction

endpackage

// File: rtl/countdown_timer_7seg_if.sv
// Control/display bundle of the countdown timer; master = board logic, slave = timer.
interface countdown_timer_7seg_if ();
  logic                          start;
  logic                          pause;
  logic                          reload;
  logic [6:0]                    load_val;
  logic [3:0]                    tens;
  logic [3:0]                    units;
  logic                          running;
  logic                          expired;
  logic [timer_pkg::SEG_W-1:0]   seg_led_1;
  logic [timer_pkg::SEG_W-1:0]   seg_led_2;

  modport master (
    output start, pause, reload, load_val,
    input  tens, units, running, expired, seg_led_1, seg_led_2
  );

  modport slave (
    input  start, pause, reload, load_val,
    output tens, units, running, expired, seg_led_1, seg_led_2
  );
endinterface

// File: rtl/countdown_timer_7seg_seg7_decode.sv
// Combinational BCD digit to 9-bit 7-segment pattern; non-BCD codes go blank.
module seg7_decode
  import timer_pkg::*;
(
  input  logic [3:0]       bcd_i,
  output logic [SEG_W-1:0] seg_o
);
  assign seg_o = seg_of(bcd_i);
endmodule

// File: rtl/countdown_timer_7seg.sv
// Two-digit BCD countdown with prescaler, run/pause/reload FSM and registered 7-seg outputs.
// Optional: define TIMER_LZ_BLANK_EN to blank the tens display while tens == 0.
module countdown_timer_7seg
  import timer_pkg::*;
#(
  parameter int CLK_HZ      = 12000000,
  parameter int TICK_HZ     = 1,
  parameter int INIT_VAL    = 24,
  parameter int AUTO_RELOAD = 1
) (
  input  logic                    clk,
  input  logic                    rst,
  countdown_timer_7seg_if.slave   tmr
);

  localparam int               DIV      = CLK_HZ / TICK_HZ;
  localparam int               PW       = $clog2(DIV);
  localparam logic [PW-1:0]    PRESC_TC = PW'(DIV - 1);
  localparam bcd_t             INIT_BCD = bin_to_bcd(7'(INIT_VAL));
  localparam logic [SEG_W-1:0] SEG_MASK = SEG_W'((1 << DP_BIT) - 1);
  localparam logic [SEG_W-1:0] SEG2_RST = seg_of(INIT_BCD.units);
`ifdef TIMER_LZ_BLANK_EN
  localparam logic [SEG_W-1:0] SEG1_RST = (INIT_BCD.tens == 4'd0) ? SEG_BLANK : seg_of(INIT_BCD.tens);
`else
  localparam logic [SEG_W-1:0] SEG1_RST = seg_of(INIT_BCD.tens);
`endif

  state_e             state_q, state_d;
  logic [PW-1:0]      presc_q, presc_d;
  bcd_t               cnt_q, cnt_d;
  bcd_t               rld_q, rld_d;
  logic               expired_q, expired_d;
  logic               running_q;
  logic [SEG_W-1:0]   seg1_q, seg1_d, seg2_q, seg2_d;
  logic [SEG_W-1:0]   dec_tens, dec_units;
  logic               tick, cnt_zero, cnt_gt1;

  assign tick     = (presc_q == PRESC_TC);
  assign cnt_zero = (cnt_q == '0);
  assign cnt_gt1  = (cnt_q.tens != 4'd0) || (cnt_q.units > 4'd1);

  always_comb begin
    state_d   = state_q;
    presc_d   = presc_q;
    cnt_d     = cnt_q;
    rld_d     = rld_q;
    expired_d = 1'b0;
    if (tmr.reload) begin
      state_d = IDLE;
      presc_d = '0;
      cnt_d   = bin_to_bcd(tmr.load_val);
      rld_d   = cnt_d;
    end else begin
      case (state_q)
        IDLE: if (tmr.start) begin
          state_d = RUN;
          presc_d = '0;
        end
        RUN: begin
          if (tmr.pause) begin
            state_d = PAUSE;
          end else if (cnt_zero && AUTO_RELOAD == 0) begin
            state_d = DONE;
            presc_d = '0;
          end else if (tick) begin
            presc_d = '0;
            if (cnt_gt1) begin
              // BCD borrow: x0 -> (x-1)9
              if (cnt_q.units == 4'd0) begin
                cnt_d.units = 4'd9;
                cnt_d.tens  = cnt_q.tens - 4'd1;
              end else begin
                cnt_d.units = cnt_q.units - 4'd1;
              end
            end else if (!cnt_zero) begin
              cnt_d     = '0;
              expired_d = 1'b1;
            end else begin
              cnt_d = rld_q;
            end
          end else begin
            presc_d = presc_q + 1'b1;
          end
        end
        PAUSE: if (tmr.start && !tmr.pause) state_d = RUN;
        default: ;
      endcase
    end
  end

  seg7_decode u_dec_tens  (.bcd_i(cnt_q.tens),  .seg_o(dec_tens));
  seg7_decode u_dec_units (.bcd_i(cnt_q.units), .seg_o(dec_units));

`ifdef TIMER_LZ_BLANK_EN
  assign seg1_d = (cnt_q.tens == 4'd0) ? SEG_BLANK : (dec_tens & SEG_MASK);
`else
  assign seg1_d = dec_tens & SEG_MASK;
`endif
  assign seg2_d = dec_units & SEG_MASK;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      presc_q   <= '0;
      cnt_q     <= INIT_BCD;
      rld_q     <= INIT_BCD;
      expired_q <= 1'b0;
      running_q <= 1'b0;
      seg1_q    <= SEG1_RST;
      seg2_q    <= SEG2_RST;
    end else begin
      state_q   <= state_d;
      presc_q   <= presc_d;
      cnt_q     <= cnt_d;
      rld_q     <= rld_d;
      expired_q <= expired_d;
      running_q <= (state_d == RUN);
      seg1_q    <= seg1_d;
      seg2_q    <= seg2_d;
    end
  end

  assign tmr.tens      = cnt_q.tens;
  assign tmr.units     = cnt_q.units;
  assign tmr.running   = running_q;
  assign tmr.expired   = expired_q;
  assign tmr.seg_led_1 = seg1_q;
  assign tmr.seg_led_2 = seg2_q;

endmodule

// File: tb/tb_countdown_timer_7seg.sv
// Bench for countdown_timer_7seg: AUTO_RELOAD=1 and =0 instances share stimulus,
// each tracked by an integer-count model; directed literals pin the model.
module tb_countdown_timer_7seg;

  localparam int DIV = 10;
  localparam int M_IDLE = 0, M_RUN = 1, M_PAUSE = 2, M_DONE = 3;

  typedef struct packed {
    int cnt;
    int rld;
    int mode;
    int phase;
    int seg_cnt;
    int exp;
  } mdl_t;

  logic clk;
  logic rst;
  logic start, pause, reload;
  logic [6:0] load_val;
  bit   chk_en;
  int   n_chk, n_err;
  int   seg_tab [10] = '{'h3F, 'h06, 'h5B, 'h4F, 'h66, 'h6D, 'h7D, 'h07, 'h7F, 'h6F};
  mdl_t ma, mb;

  countdown_timer_7seg_if if_a ();
  countdown_timer_7seg_if if_b ();

  assign if_a.start = start;  assign if_a.pause = pause;
  assign if_a.reload = reload; assign if_a.load_val = load_val;
  assign if_b.start = start;  assign if_b.pause = pause;
  assign if_b.reload = reload; assign if_b.load_val = load_val;

  countdown_timer_7seg #(.CLK_HZ(10), .TICK_HZ(1), .INIT_VAL(24), .AUTO_RELOAD(1))
    dut_a (.clk(clk), .rst(rst), .tmr(if_a));
  countdown_timer_7seg #(.CLK_HZ(10), .TICK_HZ(1), .INIT_VAL(24), .AUTO_RELOAD(0))
    dut_b (.clk(clk), .rst(rst), .tmr(if_b));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic mdl_t model_reset();
    mdl_t m;
    m.cnt = 24; m.rld = 24; m.mode = M_IDLE; m.phase = 0; m.seg_cnt = 24; m.exp = 0;
    return m;
  endfunction

  function automatic mdl_t model_step(input mdl_t m, input bit s, input bit p, input bit r,
                                      input int lv, input int ar);
    mdl_t n;
    n = m;
    n.exp = 0;
    n.seg_cnt = m.cnt;
    if (r) begin
      n.mode = M_IDLE; n.cnt = (lv > 99) ? 99 : lv; n.rld = n.cnt; n.phase = 0;
    end else if (m.mode == M_IDLE) begin
      if (s) begin n.mode = M_RUN; n.phase = 0; end
    end else if (m.mode == M_RUN) begin
      if (p) n.mode = M_PAUSE;
      else if (m.cnt == 0 && ar == 0) begin n.mode = M_DONE; n.phase = 0; end
      else if (m.phase == DIV - 1) begin
        n.phase = 0;
        if (m.cnt > 1) n.cnt = m.cnt - 1;
        else if (m.cnt == 1) begin n.cnt = 0; n.exp = 1; end
        else n.cnt = m.rld;
      end else n.phase = m.phase + 1;
    end else if (m.mode == M_PAUSE) begin
      if (s && !p) n.mode = M_RUN;
    end
    return n;
  endfunction

  function automatic int exp_seg1(input int c);
`ifdef TIMER_LZ_BLANK_EN
    if (c / 10 == 0) return 0;
`endif
    return seg_tab[c / 10];
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      ma <= model_reset();
      mb <= model_reset();
    end else begin
      ma <= model_step(ma, start, pause, reload, int'(load_val), 1);
      mb <= model_step(mb, start, pause, reload, int'(load_val), 0);
    end
  end

  task automatic chk(input string nm, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic cmp(input string nm, input mdl_t m, input int t, input int u, input int run,
                     input int ex, input int s1, input int s2);
    chk({nm, ".tens"},    t,   m.cnt / 10);
    chk({nm, ".units"},   u,   m.cnt % 10);
    chk({nm, ".running"}, run, (m.mode == M_RUN) ? 1 : 0);
    chk({nm, ".expired"}, ex,  m.exp);
    chk({nm, ".seg1"},    s1,  exp_seg1(m.seg_cnt));
    chk({nm, ".seg2"},    s2,  seg_tab[m.seg_cnt % 10]);
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      cmp("a", ma, int'(if_a.tens), int'(if_a.units), int'(if_a.running), int'(if_a.expired),
          int'(if_a.seg_led_1), int'(if_a.seg_led_2));
      cmp("b", mb, int'(if_b.tens), int'(if_b.units), int'(if_b.running), int'(if_b.expired),
          int'(if_b.seg_led_1), int'(if_b.seg_led_2));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int n;
    int prev;
    bit seen;
    start = 0; pause = 0; reload = 0; load_val = '0;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    chk_en = 1'b1;

    // reset and idle hold
    repeat (100) step();
    chk("idle_tens", int'(if_a.tens), 2);
    chk("idle_units", int'(if_a.units), 4);
    chk("idle_seg1", int'(if_a.seg_led_1), 'h05B);
    chk("idle_seg2", int'(if_a.seg_led_2), 'h066);
    chk("idle_running", int'(if_a.running), 0);
    chk("idle_expired", int'(if_a.expired), 0);

    // full countdown to expiry
    start = 1; step(); start = 0;
    n = 0;
    while (n < 400 && if_a.expired !== 1'b1) begin step(); n++; end
    chk("expiry_latency", n, 240);
    chk("expiry_tens", int'(if_a.tens), 0);
    chk("expiry_units", int'(if_a.units), 0);
    step();
    chk("expiry_one_cycle", int'(if_a.expired), 0);

    // pause mid-interval: prescaler phase survives
    prev = int'(if_a.units); seen = 0;
    for (int i = 0; i < 50 && !seen; i++) begin step(); seen = (int'(if_a.units) != prev); end
    chk("reload_tick_seen", int'(seen), 1);
    chk("auto_reload_val", int'(if_a.tens) * 10 + int'(if_a.units), 24);
    repeat (3) step();
    pause = 1;
    repeat (25) step();
    pause = 0; start = 1;
    prev = int'(if_a.units); n = 0; seen = 0;
    while (n < 30 && !seen) begin
      step(); n++;
      if (n == 1) start = 0;
      seen = (int'(if_a.units) != prev);
    end
    chk("resume_tick_edges", n, 8);

    // reload beats start; clip above 99
    reload = 1; load_val = 7'd57; start = 1; step(); reload = 0; start = 0;
    chk("load57_tens", int'(if_a.tens), 5);
    chk("load57_units", int'(if_a.units), 7);
    chk("load57_running", int'(if_a.running), 0);
    load_val = 7'd120; reload = 1; step(); reload = 0;
    chk("clip_tens", int'(if_a.tens), 9);
    chk("clip_units", int'(if_a.units), 9);

    // no auto-reload: stop in DONE
    load_val = 7'd2; reload = 1; step(); reload = 0;
    start = 1; step(); start = 0;
    repeat (40) step();
    chk("done_count", int'(if_b.tens) * 10 + int'(if_b.units), 0);
    chk("done_running", int'(if_b.running), 0);
    start = 1; step(); start = 0; step();
    chk("done_start_ignored", int'(if_b.running), 0);
    load_val = 7'd5; reload = 1; step(); reload = 0;
    chk("done_reload_exit", int'(if_b.units), 5);

    // async reset between edges
    start = 1; step(); start = 0;
    repeat (15) step();
    #2 rst = 1'b1;
    #1;
    chk("arst_tens", int'(if_a.tens), 2);
    chk("arst_units", int'(if_a.units), 4);
    chk("arst_seg1", int'(if_a.seg_led_1), 'h05B);
    chk("arst_seg2", int'(if_a.seg_led_2), 'h066);
    chk("arst_running", int'(if_a.running), 0);
    step();
    rst = 1'b0;
    load_val = 7'd7; reload = 1; step(); reload = 0; step();
`ifdef TIMER_LZ_BLANK_EN
    chk("lz_seg1", int'(if_a.seg_led_1), 'h000);
`else
    chk("lz_seg1", int'(if_a.seg_led_1), 'h03F);
`endif
    chk("lz_seg2", int'(if_a.seg_led_2), 'h007);

    // randomized run against the model
    for (int i = 0; i < 3000; i++) begin
      start    = ($urandom_range(0, 7) == 0);
      pause    = ($urandom_range(0, 15) == 0);
      reload   = ($urandom_range(0, 80) == 0);
      load_val = 7'($urandom_range(0, 127));
      step();
    end
    start = 0; pause = 0; reload = 0;
    step();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
